// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-interface receiver. Oversamples the panel lines on
// clk_in, rebuilds each shifted row pair into a column word at every latch
// pulse and delivers it on a valid/ready/last stream through a small FIFO.
// Optional build macro HUB75_RX_OE_COUNT_EN adds m_ton_cycles, the number of
// clk_in cycles with OE active during the row.
module hub75_rx #(
  parameter int NUM_COLS   = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    hub75_clk,
  input  logic                    hub75_latch,
  input  logic                    hub75_OE,
  input  logic [ADDR_W-1:0]       hub75_addr,
  input  logic [2:0]              hub75_rgb0,
  input  logic [2:0]              hub75_rgb1,
  output logic [3*NUM_COLS-1:0]   m_tdata_rgb0,
  output logic [3*NUM_COLS-1:0]   m_tdata_rgb1,
  output logic [ADDR_W-1:0]       m_taddr,
  output logic                    m_tcount_err,
`ifdef HUB75_RX_OE_COUNT_EN
  output logic [15:0]             m_ton_cycles,
`endif
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    overflow
);

  localparam int DW = 3 * NUM_COLS;
  localparam int CW = $clog2(NUM_COLS) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef HUB75_RX_OE_COUNT_EN
  localparam int WW = 2 * DW + ADDR_W + 2 + 16;
`else
  localparam int WW = 2 * DW + ADDR_W + 2;
`endif

  // Synchroniser chains: [0] first stage, [1] synced value, [2] edge copy.
  logic [2:0]        clk_sy;
  logic [2:0]        latch_sy;
  logic [ADDR_W-1:0] addr_sy1, addr_sy2;
  logic [2:0]        rgb0_sy1, rgb0_sy2;
  logic [2:0]        rgb1_sy1, rgb1_sy2;

  logic              clk_rise;
  logic              latch_rise;
  logic              latch_pend;

  logic [DW-1:0]     shift_reg0, shift_reg1;
  logic [CW-1:0]     pix_cnt;

  logic [WW-1:0]     word_in;
  logic [WW-1:0]     mem [FIFO_DEPTH];
  logic [WW-1:0]     head;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              full, push, pop, wr_en;

  // Two-flop synchronisers plus a third copy for edge detection
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_sy   <= '0;
      latch_sy <= '0;
      addr_sy1 <= '0;
      addr_sy2 <= '0;
      rgb0_sy1 <= '0;
      rgb0_sy2 <= '0;
      rgb1_sy1 <= '0;
      rgb1_sy2 <= '0;
    end else begin
      clk_sy   <= {clk_sy[1:0], hub75_clk};
      latch_sy <= {latch_sy[1:0], hub75_latch};
      addr_sy1 <= hub75_addr;
      addr_sy2 <= addr_sy1;
      rgb0_sy1 <= hub75_rgb0;
      rgb0_sy2 <= rgb0_sy1;
      rgb1_sy1 <= hub75_rgb1;
      rgb1_sy2 <= rgb1_sy1;
    end
  end

  assign clk_rise   = clk_sy[1] & ~clk_sy[2];
  assign latch_rise = latch_sy[1] & ~latch_sy[2];

  // Register the latch edge; the word is formed one cycle later so that a
  // pixel clocked in the same cycle as the latch edge is already shifted in
  // and counted, while a pixel in the push cycle belongs to the next row.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) latch_pend <= 1'b0;
    else        latch_pend <= latch_rise;
  end

  // Pixel shift registers and saturating pixel counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_reg0 <= '0;
      shift_reg1 <= '0;
      pix_cnt    <= '0;
    end else begin
      if (clk_rise) begin
        shift_reg0 <= {shift_reg0[DW-4:0], rgb0_sy2};
        shift_reg1 <= {shift_reg1[DW-4:0], rgb1_sy2};
      end
      if (latch_pend)
        pix_cnt <= clk_rise ? CW'(1) : '0;
      else if (clk_rise && pix_cnt != CW'(NUM_COLS + 1))
        pix_cnt <= pix_cnt + CW'(1);
    end
  end

`ifdef HUB75_RX_OE_COUNT_EN
  logic [1:0]  oe_sy;
  logic [15:0] on_cnt;

  // OE synchroniser and saturating on-time counter, restarted per row
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      oe_sy  <= '0;
      on_cnt <= '0;
    end else begin
      oe_sy <= {oe_sy[0], hub75_OE};
      if (latch_pend)
        on_cnt <= oe_sy[1] ? 16'd0 : 16'd1;
      else if (!oe_sy[1] && on_cnt != '1)
        on_cnt <= on_cnt + 16'd1;
    end
  end

  assign word_in = {on_cnt, shift_reg1, shift_reg0, addr_sy2,
                    (pix_cnt != CW'(NUM_COLS)), &addr_sy2};
`else
  logic unused_oe;
  assign unused_oe = hub75_OE;

  assign word_in = {shift_reg1, shift_reg0, addr_sy2,
                    (pix_cnt != CW'(NUM_COLS)), &addr_sy2};
`endif

  assign push  = latch_pend;
  assign pop   = m_tvalid & m_tready;
  assign full  = (wr_ptr - rd_ptr) == (PW + 1)'(FIFO_DEPTH);
  assign wr_en = push & (~full | pop);

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PW + 1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= word_in;
  end

  // Head of FIFO drives the stream fields, forced to zero when empty
  always_comb begin
    m_tvalid     = (wr_ptr != rd_ptr);
    head         = m_tvalid ? mem[rd_ptr[PW-1:0]] : '0;
    m_tlast      = head[0];
    m_tcount_err = head[1];
    m_taddr      = head[ADDR_W+1:2];
    m_tdata_rgb0 = head[DW+ADDR_W+1:ADDR_W+2];
    m_tdata_rgb1 = head[2*DW+ADDR_W+1:DW+ADDR_W+2];
`ifdef HUB75_RX_OE_COUNT_EN
    m_ton_cycles = head[WW-1:WW-16];
`endif
  end

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: scoreboard bench for hub75_rx. Expected words are built from a
// pixel-history model when each latch is driven and compared as the DUT
// delivers them on the stream.
module tb_hub75_rx;

  localparam int NC = 64;
  localparam int AW = 5;
  localparam int DW = 3 * NC;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          hub75_clk = 1'b0;
  logic          hub75_latch = 1'b0;
  logic          hub75_OE = 1'b1;
  logic [AW-1:0] hub75_addr = '0;
  logic [2:0]    hub75_rgb0 = '0;
  logic [2:0]    hub75_rgb1 = '0;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata_rgb0, m_tdata_rgb1;
  logic [AW-1:0] m_taddr;
  logic          m_tcount_err, m_tvalid, m_tlast, overflow;
`ifdef HUB75_RX_OE_COUNT_EN
  logic [15:0]   m_ton_cycles;
`endif

  hub75_rx #(.NUM_COLS(NC), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .hub75_clk   (hub75_clk),
    .hub75_latch (hub75_latch),
    .hub75_OE    (hub75_OE),
    .hub75_addr  (hub75_addr),
    .hub75_rgb0  (hub75_rgb0),
    .hub75_rgb1  (hub75_rgb1),
    .m_tdata_rgb0(m_tdata_rgb0),
    .m_tdata_rgb1(m_tdata_rgb1),
    .m_taddr     (m_taddr),
    .m_tcount_err(m_tcount_err),
`ifdef HUB75_RX_OE_COUNT_EN
    .m_ton_cycles(m_ton_cycles),
`endif
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .overflow    (overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [AW-1:0] addr;
    logic          err;
    logic          last;
  } word_t;

  word_t       sb[$];
  logic [2:0]  hist0[$];
  logic [2:0]  hist1[$];
  int unsigned row_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          words_seen = 0;
  int          lasts_seen = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic pixel(input logic [2:0] a, input logic [2:0] b);
    hub75_rgb0 = a;
    hub75_rgb1 = b;
    hub75_clk  = 1'b0;
    tick(2);
    hub75_clk = 1'b1;
    tick(2);
    hub75_clk = 1'b0;
    hist0.push_front(a);
    hist1.push_front(b);
    if (hist0.size() > NC) void'(hist0.pop_back());
    if (hist1.size() > NC) void'(hist1.pop_back());
    row_cnt++;
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++)
      pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  function automatic word_t model_word(input logic [AW-1:0] a);
    word_t w;
    w.r0 = '0;
    w.r1 = '0;
    for (int c = 0; c < NC; c++) begin
      if (c < hist0.size()) w.r0[3*c +: 3] = hist0[c];
      if (c < hist1.size()) w.r1[3*c +: 3] = hist1[c];
    end
    w.addr = a;
    w.err  = (row_cnt != NC);
    w.last = (a == '1);
    return w;
  endfunction

  // Raise latch and return at the point the word first reaches the stream.
  task automatic latch_row(input logic [AW-1:0] a, input bit expect_it);
    if (expect_it) sb.push_back(model_word(a));
    row_cnt = 0;
    hub75_latch = 1'b1;
    tick(4);
    hub75_latch = 1'b0;
  endtask

  // Stream monitor: every accepted word is popped from the scoreboard
  always @(negedge clk_in) begin
    if (!rst_in && m_tvalid && m_tready) begin
      check("sb_has_entry", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        word_t w;
        w = sb.pop_front();
        check("word_rgb0", m_tdata_rgb0, w.r0);
        check("word_rgb1", m_tdata_rgb1, w.r1);
        check("word_addr", m_taddr, w.addr);
        check("word_err", m_tcount_err, w.err);
        check("word_last", m_tlast, w.last);
      end
      words_seen++;
      if (m_tlast) lasts_seen++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, m_tvalid, 1'b0);
    check({tag, "_last"}, m_tlast, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_rgb0"}, m_tdata_rgb0, '0);
    check({tag, "_rgb1"}, m_tdata_rgb1, '0);
    check({tag, "_addr"}, m_taddr, '0);
    check({tag, "_err"}, m_tcount_err, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int w0, l0;
    tick(3);
    check_all_zero("reset");
    rst_in = 1'b0;
    tick(3);

    // Full row with a known ramp; also measures latch-to-valid latency
    hub75_addr = 5;
    for (int c = 0; c < NC; c++) pixel(3'(c), ~3'(c));
    sb.push_back(model_word(5));
    row_cnt = 0;
    hub75_latch = 1'b1;
    tick(3);
    check("latency_early", m_tvalid, 1'b0);
    tick(1);
    hub75_latch = 1'b0;
    check("latency_valid", m_tvalid, 1'b1);
    check("ramp_addr", m_taddr, 5'd5);
    check("ramp_err", m_tcount_err, 1'b0);
    check("ramp_last", m_tlast, 1'b0);
    check("ramp_col63_rgb0", m_tdata_rgb0[DW-1:DW-3], 3'b000);
    check("ramp_col63_rgb1", m_tdata_rgb1[DW-1:DW-3], 3'b111);
    check("ramp_col0_rgb0", m_tdata_rgb0[2:0], 3'b111);
    check("ramp_col0_rgb1", m_tdata_rgb1[2:0], 3'b000);
    tick(2);

    // Short row and over-long row
    hub75_addr = 7;
    rand_pixels(NC - 1);
    latch_row(7, 1);
    check("short_err", m_tcount_err, 1'b1);
    tick(2);
    hub75_addr = 8;
    rand_pixels(NC + 6);
    latch_row(8, 1);
    check("long_err", m_tcount_err, 1'b1);
    check("long_col0", m_tdata_rgb0[2:0], hist0[0]);
    tick(2);

    // Full frame of 32 rows
    w0 = words_seen;
    l0 = lasts_seen;
    for (int a = 0; a < 32; a++) begin
      hub75_addr = 5'(a);
      rand_pixels(NC);
      latch_row(5'(a), 1);
      if (a == 31) check("frame_tlast31", m_tlast, 1'b1);
      tick(2);
    end
    check("frame_words", words_seen - w0, 32);
    check("frame_lasts", lasts_seen - l0, 1);

    // Back-pressure: two rows buffered, third dropped
    m_tready = 1'b0;
    w0 = words_seen;
    for (int r = 0; r < 3; r++) begin
      hub75_addr = 5'(10 + r);
      rand_pixels(NC);
      latch_row(5'(10 + r), r < 2);
      tick(2);
    end
    check("stall_valid", m_tvalid, 1'b1);
    check("stall_overflow", overflow, 1'b1);
    check("stall_addr", m_taddr, 5'd10);
    check("stall_rgb0", m_tdata_rgb0, sb[0].r0);
    check("stall_rgb1", m_tdata_rgb1, sb[0].r1);
    tick(5);
    check("stall_hold_rgb0", m_tdata_rgb0, sb[0].r0);
    m_tready = 1'b1;
    tick(4);
    check("stall_delivered", words_seen - w0, 2);
    check("stall_drained", m_tvalid, 1'b0);

    // Reset in the middle of a row
    hub75_addr = 3;
    rand_pixels(30);
    rst_in = 1'b1;
    tick(2);
    check_all_zero("midrst");
    hist0.delete();
    hist1.delete();
    row_cnt = 0;
    rst_in = 1'b0;
    tick(3);
    rand_pixels(NC);
    latch_row(3, 1);
    check("postrst_err", m_tcount_err, 1'b0);
    check("postrst_rgb0", m_tdata_rgb0, sb[0].r0);
    tick(2);

`ifdef HUB75_RX_OE_COUNT_EN
    // OE on-time inside a row
    hub75_addr = 9;
    rand_pixels(10);
    hub75_OE = 1'b0;
    tick(100);
    hub75_OE = 1'b1;
    rand_pixels(NC - 10);
    latch_row(9, 1);
    check("oe_cycles", m_ton_cycles, 16'd100);
    tick(2);
`endif

    tick(10);
    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receiver/decoder for the HUB75 panel interface driven by the panel output block.
- Oversamples the six RGB lines and led_clk, latch, OE and address on sysclk, then rebuilds each shifted row pair into a column-data word.
- Emits one word per latch pulse on a valid/ready/last stream.
- Used for on-board loopback checking of the panel output and as a bench monitor.

Parameters:
- NUM_COLS, 64, pixels shifted per latch per half-panel.
- ADDR_W, 5, width of hub75_addr; 2^ADDR_W = SCAN_RATE rows.
- FIFO_DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
- clk_in  input  1  sysclk (24 MHz); all logic on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- hub75_clk  input  1  panel shift clock; pixel sampled on its rising edge.
- hub75_latch  input  1  row latch; a rising edge closes the row.
- hub75_OE  input  1  output enable, active low.
- hub75_addr  input  ADDR_W  row address.
- hub75_rgb0  input  3  upper-half pixel {r,g,b}.
- hub75_rgb1  input  3  lower-half pixel {r,g,b}.
- m_tdata_rgb0  output  3*NUM_COLS  upper row; column c at bits [3c+2:3c].
- m_tdata_rgb1  output  3*NUM_COLS  lower row, same packing.
- m_taddr  output  ADDR_W  address captured at the latch edge.
- m_tcount_err  output  1  pixel count at latch was not NUM_COLS.
- m_tvalid  output  1  word available.
- m_tready  input  1  downstream accept.
- m_tlast  output  1  word is for address 2^ADDR_W-1.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Synchronisers
  - Every hub75_* input passes through a 2-flop synchroniser.
  - Edge detection uses a third registered copy.
  - All timing below counts from the synchronised signals.
- Shift capture
  - On a synced hub75_clk rising edge: shift_reg0 = {shift_reg0[3*NUM_COLS-4:0], rgb0}, and likewise shift_reg1 with rgb1.
  - The first pixel clocked after a latch ends up at column NUM_COLS-1; the last pixel ends up at column 0.
  - pix_cnt (width clog2(NUM_COLS)+1) increments and saturates at NUM_COLS+1. Extra clocks keep shifting, so the register holds the most recent NUM_COLS pixels.
- Latch
  - On a synced latch rising edge, form a word: shift registers, synced addr, count_err = (pix_cnt != NUM_COLS), last = (addr == all-ones).
  - Push the word into the FIFO and clear pix_cnt to 0. The shift registers are not cleared.
  - If a clk edge and a latch edge occur in the same cycle, the shifted-in pixel is included in the word and counted.
- FIFO
  - FIFO_DEPTH entries; the head drives the m_t* outputs.
  - Transfer happens when m_tvalid && m_tready.
  - m_tdata and the other m_t* fields hold stable while m_tvalid=1 and m_tready=0.
  - Push and pop in the same cycle when full: allowed, no drop.
  - Push when full with no pop: the new word is discarded and overflow is set. overflow clears only on reset.
- Latency: word visible on m_tvalid 4 clk_in cycles after the raw latch rises (2 sync stages + edge register + FIFO write), when the FIFO was empty.
- hub75_OE is ignored unless the optional feature is enabled.
- Reset, asynchronous at any time including mid-row:
  - Shift registers, pix_cnt, FIFO pointers and all sync flops go to 0.
  - All outputs go to 0: m_tvalid=0, m_tlast=0, overflow=0, data/addr/err fields 0.
  - A partial row that straddles reset release is counted from 0, so its word reports count_err=1 unless exactly NUM_COLS clocks follow release.

Optional Feature:
- Macro: HUB75_RX_OE_COUNT_EN.
- Enabled:
  - Adds output m_ton_cycles (16 bits).
  - A counter increments on each clk_in cycle with synced OE=0, saturating at 0xFFFF.
  - The counter value is captured into the word at the latch edge, then cleared. The latch-edge cycle counts toward the new row.
- Disabled: the port and counter are absent and OE is unused.

Test Plan:
- 64 hub75_clk pulses with rgb0 = c[2:0] and rgb1 = ~c[2:0] for pixel index c, addr=5, then latch -> one word:
  - m_taddr=5, m_tcount_err=0, m_tlast=0.
  - column 63 = 3'b000 on rgb0 and 3'b111 on rgb1 (first pixel, c=0).
  - column 0 = 3'b111 on rgb0 and 3'b000 on rgb1 (last pixel, c=63).
- 63 pulses then latch -> m_tcount_err=1. Then 70 pulses then latch -> m_tcount_err=1, and the word holds the last 64 pixels.
- addr=31 row -> m_tlast=1. Full 32-row frame -> 32 words, addresses 0..31, m_tlast asserted only on the final word.
- m_tready=0, 3 latched rows -> first 2 words held stable and m_tvalid=1, overflow=1. Release m_tready -> rows 0 and 1 delivered in order, the third never appears.
- Assert rst_in after 30 pulses, release, then 64 pulses and latch -> all outputs 0 during reset; the word afterwards has count_err=0 and contains only post-reset pixels.
- HUB75_RX_OE_COUNT_EN defined, OE held low for 100 cycles within a row -> m_ton_cycles=100. Undefined -> the design builds without the port.
